// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_ctrl
// Description : Walks the PWM compare value toward a commanded target, one
//               clamped step every (hold+1) period starts.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
   parameter int WIDTH      = 10,
   parameter int STEP_WIDTH = 4,
   parameter int HOLD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   input  logic [WIDTH-1:0]      cmd_target_i,
   input  logic [STEP_WIDTH-1:0] cmd_step_i,
   input  logic [HOLD_WIDTH-1:0] cmd_hold_i,
   input  logic                  freeze_i,
   input  logic                  period_start_i,
   output logic [WIDTH-1:0]      cmp_value_o,
   output logic                  pwm_set_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FADE = 1'b1
   } state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_target;
   logic [STEP_WIDTH-1:0] r_step;
   logic [HOLD_WIDTH-1:0] r_hold;
   logic [HOLD_WIDTH-1:0] r_hold_cnt;

   logic [WIDTH:0]        w_cur_ext;
   logic [WIDTH:0]        w_tgt_ext;
   logic [WIDTH:0]        w_step_ext;
   logic [WIDTH:0]        w_sum;
   logic [WIDTH:0]        w_diff;
   logic [WIDTH-1:0]      w_next;
   logic                  w_tick;

   assign w_cur_ext  = {1'b0, cmp_value_o};
   assign w_tgt_ext  = {1'b0, r_target};
   assign w_step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, r_step};
   assign w_sum      = w_cur_ext + w_step_ext;
   assign w_diff     = w_cur_ext - w_step_ext;
   assign w_tick     = (r_state == FADE) && period_start_i && !freeze_i;

   // Wide intermediates let both directions clamp at the target without wrapping.
   always_comb begin
      w_next = r_target;
      if (r_step != '0) begin
         if (w_tgt_ext > w_cur_ext) begin
            w_next = (w_sum > w_tgt_ext) ? r_target : w_sum[WIDTH-1:0];
         end else if (w_cur_ext >= w_step_ext) begin
            w_next = (w_diff < w_tgt_ext) ? r_target : w_diff[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_target    <= '0;
         r_step      <= '0;
         r_hold      <= '0;
         r_hold_cnt  <= '0;
         cmp_value_o <= '0;
         pwm_set_o   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         pwm_set_o <= 1'b0;
         done_o    <= 1'b0;
         // A command always takes precedence over a coincident period start.
         if (cmd_valid_i) begin
            r_target   <= cmd_target_i;
            r_step     <= cmd_step_i;
            r_hold     <= cmd_hold_i;
            r_hold_cnt <= cmd_hold_i;
            if (cmd_target_i == cmp_value_o) begin
               r_state <= IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b1;
            end else begin
               r_state <= FADE;
               busy_o  <= 1'b1;
            end
         end else if (w_tick) begin
            if (r_hold_cnt != '0) begin
               r_hold_cnt <= r_hold_cnt - 1'b1;
            end else begin
               r_hold_cnt  <= r_hold;
               cmp_value_o <= w_next;
               pwm_set_o   <= 1'b1;
               if (w_next == r_target) begin
                  r_state <= IDLE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_ctrl
// Description : Scoreboard bench for pwm_fade_ctrl with directed fade vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

   logic       clk;
   logic       rst;
   logic       cmd_valid_i;
   logic [9:0] cmd_target_i;
   logic [3:0] cmd_step_i;
   logic [7:0] cmd_hold_i;
   logic       freeze_i;
   logic       period_start_i;
   logic [9:0] cmp_value_o;
   logic       pwm_set_o;
   logic       busy_o;
   logic       done_o;

   typedef struct {
      logic [9:0] cmp;
      logic       set;
      logic       done;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   pwm_fade_ctrl #(.WIDTH(10), .STEP_WIDTH(4), .HOLD_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_target_i   (cmd_target_i),
      .cmd_step_i     (cmd_step_i),
      .cmd_hold_i     (cmd_hold_i),
      .freeze_i       (freeze_i),
      .period_start_i (period_start_i),
      .cmp_value_o    (cmp_value_o),
      .pwm_set_o      (pwm_set_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every output event (load strobe or done pulse) must match the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (pwm_set_o || done_o) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event: got cmp=%0d set=%0b done=%0b busy=%0b, required no event",
                        cmp_value_o, pwm_set_o, done_o, busy_o);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (cmp_value_o !== e.cmp || pwm_set_o !== e.set || done_o !== e.done || busy_o !== e.busy) begin
                  bad++;
                  $display("FAIL event: got cmp=%0d set=%0b done=%0b busy=%0b, required cmp=%0d set=%0b done=%0b busy=%0b",
                           cmp_value_o, pwm_set_o, done_o, busy_o, e.cmp, e.set, e.done, e.busy);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic [9:0] cmp, input logic set, input logic done, input logic busy);
      exp_t e;
      e.cmp = cmp; e.set = set; e.done = done; e.busy = busy;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic cmd(input logic [9:0] tgt, input logic [3:0] stp, input logic [7:0] hld);
      cmd_valid_i  = 1'b1;
      cmd_target_i = tgt;
      cmd_step_i   = stp;
      cmd_hold_i   = hld;
      tick();
      cmd_valid_i  = 1'b0;
      tick();
   endtask

   task automatic pstart();
      period_start_i = 1'b1;
      tick();
      period_start_i = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; cmd_valid_i = 1'b0; cmd_target_i = '0; cmd_step_i = '0;
      cmd_hold_i = '0; freeze_i = 1'b0; period_start_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_cmp", cmp_value_o, 0);
      chk("reset_set", pwm_set_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_done", done_o, 0);
      pstart();

      // Up fade 0 -> 10, step 3, hold 0
      cmd(10'd10, 4'd3, 8'd0);
      chk("up_busy", busy_o, 1);
      expect_ev(10'd3, 1, 0, 1);  pstart();
      expect_ev(10'd6, 1, 0, 1);  pstart();
      expect_ev(10'd9, 1, 0, 1);  pstart();
      expect_ev(10'd10, 1, 1, 0); pstart();
      chk("up_idle_busy", busy_o, 0);

      // Down fade 10 -> 0, step 4, hold 2
      cmd(10'd0, 4'd4, 8'd2);
      pstart(); pstart();
      expect_ev(10'd6, 1, 0, 1); pstart();
      pstart(); pstart();
      expect_ev(10'd2, 1, 0, 1); pstart();
      pstart(); pstart();
      expect_ev(10'd0, 1, 1, 0); pstart();
      chk("down_final", cmp_value_o, 0);

      // Jump and saturation
      cmd(10'd1023, 4'd0, 8'd0);
      expect_ev(10'd1023, 1, 1, 0); pstart();
      cmd(10'd1020, 4'd0, 8'd0);
      expect_ev(10'd1020, 1, 1, 0); pstart();
      cmd(10'd1023, 4'd15, 8'd0);
      expect_ev(10'd1023, 1, 1, 0); pstart();
      chk("sat_final", cmp_value_o, 1023);

      // Retarget with coincident period start
      cmd(10'd0, 4'd0, 8'd0);
      expect_ev(10'd0, 1, 1, 0); pstart();
      cmd(10'd10, 4'd3, 8'd0);
      expect_ev(10'd3, 1, 0, 1); pstart();
      expect_ev(10'd6, 1, 0, 1); pstart();
      cmd_valid_i = 1'b1; cmd_target_i = 10'd2; cmd_step_i = 4'd1; cmd_hold_i = 8'd0;
      period_start_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0; period_start_i = 1'b0;
      tick();
      chk("collide_hold", cmp_value_o, 6);
      expect_ev(10'd5, 1, 0, 1); pstart();
      expect_ev(10'd4, 1, 0, 1); pstart();
      expect_ev(10'd3, 1, 0, 1); pstart();
      expect_ev(10'd2, 1, 1, 0); pstart();

      // Equal target: done only, no load
      expect_ev(10'd2, 0, 1, 0);
      cmd(10'd2, 4'd5, 8'd0);
      chk("equal_busy", busy_o, 0);
      pstart();

      // Freeze pauses stepping
      cmd(10'd8, 4'd2, 8'd0);
      freeze_i = 1'b1;
      for (int i = 0; i < 5; i++) pstart();
      chk("freeze_cmp", cmp_value_o, 2);
      chk("freeze_busy", busy_o, 1);
      freeze_i = 1'b0;
      expect_ev(10'd4, 1, 0, 1); pstart();
      expect_ev(10'd6, 1, 0, 1); pstart();
      expect_ev(10'd8, 1, 1, 0); pstart();

      // Reset mid-fade
      cmd(10'd0, 4'd1, 8'd0);
      expect_ev(10'd7, 1, 0, 1); pstart();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst2_cmp", cmp_value_o, 0);
      chk("rst2_busy", busy_o, 0);
      chk("rst2_set", pwm_set_o, 0);
      pstart();
      chk("rst2_after_ps", cmp_value_o, 0);

      tick(); tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
